// File: rtl/pc_trace_recorder_pkg.sv
// Shared CPU package: trace FSM encoding and history entry layout.
// Entry fields are sized for the widest supported PC/instruction.
package pc_trace_recorder_pkg;

  localparam int unsigned TRACE_W = 64;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } trace_state_t;

  typedef struct packed {
    logic [TRACE_W-1:0] pc;
    logic [TRACE_W-1:0] inst;
    logic               valid;
  } trace_entry_t;

  function automatic trace_entry_t mk_entry(
    input logic [TRACE_W-1:0] pc,
    input logic [TRACE_W-1:0] inst,
    input logic               valid
  );
    trace_entry_t e;
    e.pc    = pc;
    e.inst  = inst;
    e.valid = valid;
    return e;
  endfunction

endpackage

// File: rtl/trace_shift_buffer.sv
// PC history shift register: entry 0 newest, DEPTH-1 oldest.
// Exposes the entry about to become oldest for commit generation.
module trace_shift_buffer
  import pc_trace_recorder_pkg::*;
#(
  parameter int              WIDTH    = 32,
  parameter int              DEPTH    = 5,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  localparam int             IW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  trace_entry_t     load,
  input  logic [IW-1:0]    rd_idx,
  output trace_entry_t     rd_entry,
  output trace_entry_t     pre_tail,
  output logic [WIDTH-1:0] head_pc,
  output logic             mid_valid
);

  trace_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      mem[0].pc <= TRACE_W'(RESET_PC);
    end else if (shift_en) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        mem[i] <= mem[i-1];
      end
      mem[0] <= load;
    end
  end

  always_comb begin
    rd_entry = '0;
    if (int'({1'b0, rd_idx}) < DEPTH) begin
      rd_entry = mem[rd_idx];
    end
  end

  always_comb begin
    mid_valid = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      mid_valid = mid_valid | mem[i].valid;
    end
  end

  assign pre_tail = mem[DEPTH-2];
  assign head_pc  = mem[0].pc[WIDTH-1:0];

endmodule

// File: rtl/pc_trace_recorder.sv
// Fetch-PC trace recorder: captures PC changes into a history
// buffer and commits the oldest entries until drained or capped.
module pc_trace_recorder
  import pc_trace_recorder_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 5,
  parameter int               MAX_COUNT = 5000,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  localparam int              IW        = $clog2(DEPTH),
  localparam int              CW        = $clog2(MAX_COUNT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] inst,
  input  logic             sample_en,
  input  logic             flush,
  input  logic [IW-1:0]    rd_idx,
  output logic [WIDTH-1:0] rd_pc,
  output logic [WIDTH-1:0] rd_inst,
  output logic             rd_valid,
  output logic             commit_valid,
  output logic [WIDTH-1:0] commit_pc,
  output logic [WIDTH-1:0] commit_inst,
  output logic [CW-1:0]    commit_count,
  output logic             done
);

  trace_state_t     state, state_nx;
  trace_entry_t     load, rd_e, pre_tail;
  logic             shift_en, commit_fire, cap, mid_valid;
  logic [WIDTH-1:0] head_pc;
  logic [CW-1:0]    count_nx;
  logic             unused_hi;

  trace_shift_buffer #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .shift_en  (shift_en),
    .load      (load),
    .rd_idx    (rd_idx),
    .rd_entry  (rd_e),
    .pre_tail  (pre_tail),
    .head_pc   (head_pc),
    .mid_valid (mid_valid)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_RUN;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    shift_en = 1'b0;
    cap      = sample_en && (pc != head_pc);
    load     = mk_entry(TRACE_W'(RESET_PC), '0, 1'b0);
    unique case (state)
      ST_RUN: begin
        shift_en = cap;
        load     = mk_entry(TRACE_W'(pc), TRACE_W'(inst), 1'b1);
        if (flush) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        shift_en = mid_valid;
        if (!mid_valid) state_nx = ST_DONE;
      end
      ST_DONE: state_nx = ST_DONE;
      default: state_nx = ST_RUN;
    endcase
    commit_fire = shift_en && pre_tail.valid;
    count_nx    = commit_count + CW'(1);
    // Hitting the cap wins over a pending flush or drain step
    if (commit_fire && count_nx == CW'(MAX_COUNT)) begin
      state_nx = ST_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      commit_valid <= 1'b0;
      commit_pc    <= '0;
      commit_inst  <= '0;
      commit_count <= '0;
    end else begin
      commit_valid <= commit_fire;
      if (commit_fire) begin
        commit_pc    <= pre_tail.pc[WIDTH-1:0];
        commit_inst  <= pre_tail.inst[WIDTH-1:0];
        commit_count <= count_nx;
      end
    end
  end

  assign rd_pc     = rd_e.pc[WIDTH-1:0];
  assign rd_inst   = rd_e.inst[WIDTH-1:0];
  assign rd_valid  = rd_e.valid;
  assign done      = (state == ST_DONE);
  assign unused_hi = ^{rd_e, pre_tail};

endmodule

// File: tb/tb_pc_trace_recorder.sv
// Directed bench for pc_trace_recorder: default DUT plus a
// MAX_COUNT=3 instance sharing the same stimulus.
module tb_pc_trace_recorder;

  logic        clk = 1'b0;
  logic        reset, sample_en, flush;
  logic [31:0] pc, inst;
  logic [2:0]  rd_idx;

  logic [31:0] rd_pc, rd_inst, commit_pc, commit_inst;
  logic        rd_valid, commit_valid, done;
  logic [12:0] commit_count;

  logic [31:0] rd_pc2, rd_inst2, commit_pc2, commit_inst2;
  logic        rd_valid2, commit_valid2, done2;
  logic [1:0]  commit_count2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_trace_recorder #(
    .WIDTH(32), .DEPTH(5), .MAX_COUNT(5000), .RESET_PC(32'h100)
  ) dut (
    .clk(clk), .reset(reset), .pc(pc), .inst(inst),
    .sample_en(sample_en), .flush(flush), .rd_idx(rd_idx),
    .rd_pc(rd_pc), .rd_inst(rd_inst), .rd_valid(rd_valid),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_inst(commit_inst), .commit_count(commit_count),
    .done(done)
  );

  pc_trace_recorder #(
    .WIDTH(32), .DEPTH(5), .MAX_COUNT(3), .RESET_PC(32'h0)
  ) dut2 (
    .clk(clk), .reset(reset), .pc(pc), .inst(inst),
    .sample_en(sample_en), .flush(flush), .rd_idx(rd_idx),
    .rd_pc(rd_pc2), .rd_inst(rd_inst2), .rd_valid(rd_valid2),
    .commit_valid(commit_valid2), .commit_pc(commit_pc2),
    .commit_inst(commit_inst2), .commit_count(commit_count2),
    .done(done2)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [31:0] v);
    pc   = v;
    inst = v ^ 32'hA500_0000;
    tick();
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    sample_en = 1'b0;
    flush     = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    int n, n2;
    logic [31:0] got [$];
    logic [31:0] exp_pc [3];
    logic [31:0] g;

    reset = 1'b0; sample_en = 1'b0; flush = 1'b0;
    pc = '0; inst = '0; rd_idx = '0;
    tick(); tick();

    // reset state
    chk("rst_cv", commit_valid, 0);
    chk("rst_cnt", commit_count, 0);
    chk("rst_cpc", commit_pc, 0);
    chk("rst_done", done, 0);
    chk("rst_v0", rd_valid, 0);
    chk("rst_pc0", rd_pc, 32'h100);
    rd_idx = 3'd1; #1;
    chk("rst_pc1", rd_pc, 0);
    rd_idx = 3'd5; #1;
    chk("rst_oob_v", rd_valid, 0);
    rd_idx = 3'd0;

    // five captures -> one commit of pc 4
    reset = 1'b1; sample_en = 1'b1;
    feed(32'h4); feed(32'h8); feed(32'hC); feed(32'h10);
    chk("cap4_cv", commit_valid, 0);
    feed(32'h14);
    chk("cap5_cv", commit_valid, 1);
    chk("cap5_cpc", commit_pc, 32'h4);
    chk("cap5_cinst", commit_inst, 32'hA500_0004);
    chk("cap5_cnt", commit_count, 1);
    tick();
    chk("hold_cv", commit_valid, 0);
    chk("hold_cpc", commit_pc, 32'h4);
    chk("hold_cnt", commit_count, 1);
    rd_idx = 3'd4; #1;
    chk("hist4_pc", rd_pc, 32'h4);
    chk("hist4_v", rd_valid, 1);
    rd_idx = 3'd0; #1;
    chk("hist0_pc", rd_pc, 32'h14);

    // repeated pc and stalled sampling produce nothing
    n = 0;
    repeat (10) begin
      tick();
      if (commit_valid) n++;
    end
    chk("same_pc_commits", n, 0);
    sample_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      feed(32'h200 + 32'(4 * i));
      if (commit_valid) n++;
    end
    chk("stall_commits", n, 0);
    chk("stall_cnt", commit_count, 1);
    chk("stall_pc0", rd_pc, 32'h14);

    // flush drain after three captures
    do_reset();
    sample_en = 1'b1;
    feed(32'h4); feed(32'h8); feed(32'hC);
    sample_en = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_done", done, 0);
    chk("fl_cv", commit_valid, 0);
    tick();
    chk("dr1_cv", commit_valid, 0);
    tick();
    chk("dr2_cv", commit_valid, 1);
    chk("dr2_cpc", commit_pc, 32'h4);
    chk("dr2_cnt", commit_count, 1);
    tick();
    chk("dr3_cv", commit_valid, 1);
    chk("dr3_cpc", commit_pc, 32'h8);
    tick();
    chk("dr4_cv", commit_valid, 1);
    chk("dr4_cpc", commit_pc, 32'hC);
    chk("dr4_done", done, 0);
    tick();
    chk("dr5_cv", commit_valid, 0);
    chk("dr5_done", done, 1);
    chk("dr5_cnt", commit_count, 3);
    sample_en = 1'b1; flush = 1'b1;
    feed(32'h300); feed(32'h304);
    flush = 1'b0;
    chk("dn_done", done, 1);
    chk("dn_cnt", commit_count, 3);
    chk("dn_cv", commit_valid, 0);
    chk("dn_pc0", rd_pc, 32'h100);
    chk("dn_v0", rd_valid, 0);
    rd_idx = 3'd4; #1;
    chk("dn_pc4", rd_pc, 32'hC);
    rd_idx = 3'd0;

    // reset in the middle of a drain
    do_reset();
    sample_en = 1'b1;
    feed(32'h4); feed(32'h8); feed(32'hC); feed(32'h10);
    sample_en = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("md_cv", commit_valid, 1);
    chk("md_cpc", commit_pc, 32'h4);
    reset = 1'b0;
    tick();
    chk("mr_cv", commit_valid, 0);
    chk("mr_cpc", commit_pc, 0);
    chk("mr_cinst", commit_inst, 0);
    chk("mr_cnt", commit_count, 0);
    chk("mr_done", done, 0);
    chk("mr_pc0", rd_pc, 32'h100);
    chk("mr_v0", rd_valid, 0);
    reset = 1'b1; sample_en = 1'b1;
    feed(32'h44);
    chk("mr_run_pc0", rd_pc, 32'h44);
    chk("mr_run_v0", rd_valid, 1);
    tick();
    chk("mr_run_done", done, 0);

    // flush together with a new pc
    do_reset();
    sample_en = 1'b1;
    feed(32'h4); feed(32'h8);
    flush = 1'b1;
    feed(32'h20);
    flush = 1'b0; sample_en = 1'b0;
    chk("ff_pc0", rd_pc, 32'h20);
    chk("ff_v0", rd_valid, 1);
    n = 0;
    while (!done && n < 12) begin
      tick();
      if (commit_valid) got.push_back(commit_pc);
      n++;
    end
    chk("ff_done", done, 1);
    chk("ff_ncommit", got.size(), 3);
    exp_pc = '{32'h4, 32'h8, 32'h20};
    for (int i = 0; i < 3; i++) begin
      g = (i < got.size()) ? got[i] : 32'hDEAD_BEEF;
      chk($sformatf("ff_commit%0d", i), g, exp_pc[i]);
    end
    chk("ff_cnt", commit_count, 3);

    // commit cap on the MAX_COUNT=3 instance
    do_reset();
    sample_en = 1'b1;
    n2 = 0;
    for (int i = 0; i < 10; i++) begin
      feed(32'h1000 + 32'(4 * i));
      if (commit_valid2) n2++;
    end
    repeat (3) begin
      tick();
      if (commit_valid2) n2++;
    end
    chk("cap_ncommit", n2, 3);
    chk("cap_done", done2, 1);
    chk("cap_cnt", commit_count2, 3);
    chk("cap_cpc", commit_pc2, 32'h1008);
    rd_idx = 3'd0; #1;
    chk("cap_pc0", rd_pc2, 32'h1018);
    rd_idx = 3'd4; #1;
    chk("cap_pc4", rd_pc2, 32'h1008);
    chk("main_run_done", done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
